// File: rtl/decompression_engine.sv
// Two-stage valid/ready decoder for the 12-bit mantissa / 4-bit exponent format.
// Optional build macro DECOMP_ROUND_EN sets the midpoint bit of the truncated range.
module decompression_engine (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [11:0] mantissa_i,
   input  logic [3:0]  exponent_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [23:0] num_o,
   output logic        err_o,
   input  logic        ready_i,
   output logic [7:0]  err_cnt_o
);

   logic        s1_valid_q;
   logic [11:0] s1_man_q;
   logic [3:0]  s1_sh_q;
   logic        s1_one_q;
   logic        s1_ill_q;

   logic        valid_q;
   logic [23:0] num_q, num_d;
   logic        err_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        adv;

   assign adv     = ~valid_q | ready_i;
   assign ready_o = (adv | ~s1_valid_q) & ~reset;

   // e==0 stores shift 0 and no implicit one, so one shifter covers both cases
   always_comb begin
      num_d = {11'd0, s1_one_q, s1_man_q} << s1_sh_q;
`ifdef DECOMP_ROUND_EN
      if (s1_sh_q != 4'd0) num_d = num_d | (24'd1 << (s1_sh_q - 4'd1));
`endif
      if (s1_ill_q) num_d = 24'hFFFFFF;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (valid_q && ready_i && err_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_man_q   <= 12'h000;
         s1_sh_q    <= 4'd0;
         s1_one_q   <= 1'b0;
         s1_ill_q   <= 1'b0;
         valid_q    <= 1'b0;
         num_q      <= 24'h0;
         err_q      <= 1'b0;
         cnt_q      <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
         if (ready_o) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
               s1_man_q <= mantissa_i;
               s1_sh_q  <= (exponent_i == 4'd0) ? 4'd0 : exponent_i - 4'd1;
               s1_one_q <= (exponent_i != 4'd0);
               s1_ill_q <= (exponent_i >= 4'd13);
            end
         end
         // bubbles advance valid only, so idle cycles leave num_o/err_o untouched
         if (adv) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               num_q <= num_d;
               err_q <= s1_ill_q;
            end
         end
      end
   end

   assign valid_o   = valid_q;
   assign num_o     = num_q;
   assign err_o     = err_q;
   assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_decompression_engine.sv
// Self-checking bench for decompression_engine: directed tests plus a
// background scoreboard comparing every output transfer to a decode model.
module tb_decompression_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_i = 1'b0;
   logic [11:0] mantissa_i = 12'h0;
   logic [3:0]  exponent_i = 4'h0;
   logic        ready_o;
   logic        valid_o;
   logic [23:0] num_o;
   logic        err_o;
   logic        ready_i = 1'b1;
   logic [7:0]  err_cnt_o;

   int checks = 0;
   int failures = 0;

   decompression_engine dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .mantissa_i(mantissa_i),
      .exponent_i(exponent_i), .ready_o(ready_o), .valid_o(valid_o),
      .num_o(num_o), .err_o(err_o), .ready_i(ready_i), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   // {err, num} from the format's decode rule
   function automatic logic [24:0] ref_decode(input logic [11:0] m, input logic [3:0] e);
      int v;
      if (e == 4'd0) return {13'h0000, m};
      if (e > 4'd12) return {1'b1, 24'hFFFFFF};
      v = (4096 + int'(m)) * (1 << (int'(e) - 1));
`ifdef DECOMP_ROUND_EN
      if (e >= 4'd2) v = v + (1 << (int'(e) - 2));
`endif
      return {1'b0, v[23:0]};
   endfunction

   // scoreboard: beats in flight, error count model, stall stability
   logic [24:0] exp_q[$];
   int          cnt_m = 0;
   bit          mon_en = 0;
   bit          stall_q = 0;
   logic [23:0] held_num;
   logic        held_err;
   logic [24:0] head;
   logic        exp_rdy;

   always @(negedge clk) begin
      if (reset || !mon_en) begin
         exp_q.delete();
         cnt_m   = 0;
         stall_q = 0;
      end else begin
         exp_rdy = !(exp_q.size() == 2 && !ready_i);
         checks++;
         if (ready_o !== exp_rdy) begin
            failures++;
            $display("FAIL ready_o: got %b expected %b (in flight %0d)", ready_o, exp_rdy, exp_q.size());
         end
         checks++;
         if (err_cnt_o !== 8'(cnt_m)) begin
            failures++;
            $display("FAIL err_cnt_o: got %0d expected %0d", err_cnt_o, cnt_m);
         end
         if (stall_q) begin
            checks++;
            if (num_o !== held_num || err_o !== held_err) begin
               failures++;
               $display("FAIL stall_hold: got %h/%b expected %h/%b", num_o, err_o, held_num, held_err);
            end
         end
         if (valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL extra_beat: got num %h with no beat in flight", num_o);
            end else begin
               head = exp_q.pop_front();
               if (num_o !== head[23:0] || err_o !== head[24]) begin
                  failures++;
                  $display("FAIL scoreboard: got %h/%b expected %h/%b", num_o, err_o, head[23:0], head[24]);
               end
               if (head[24] && cnt_m < 255) cnt_m++;
            end
         end
         if (valid_i && ready_o) exp_q.push_back(ref_decode(mantissa_i, exponent_i));
         stall_q  = valid_o && !ready_i;
         held_num = num_o;
         held_err = err_o;
      end
   end

   task automatic test_reset();
      reset = 1'b1; valid_i = 1'b1; mantissa_i = 12'h5A5; exponent_i = 4'd3; ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b0 || num_o !== 24'h0 || err_o !== 1'b0 || err_cnt_o !== 8'h0) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b vld=%b num=%h err=%b cnt=%h expected 0/0/000000/0/00",
                  ready_o, valid_o, num_o, err_o, err_cnt_o);
      end
      @(posedge clk); #1;
      reset = 1'b0; valid_i = 1'b0;
      mon_en = 1;
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: got rdy=%b vld=%b expected 1/0", ready_o, valid_o);
      end
   endtask

   task automatic test_basic();
      logic [11:0] vm[6] = '{12'hABC, 12'h000, 12'h234, 12'hFFF, 12'h800, 12'h000};
      logic [3:0]  ve[6] = '{4'd0, 4'd1, 4'd9, 4'd12, 4'd5, 4'd0};
`ifdef DECOMP_ROUND_EN
      logic [23:0] vx[6] = '{24'h000ABC, 24'h001000, 24'h123480, 24'hFFFC00, 24'h018008, 24'h000000};
`else
      logic [23:0] vx[6] = '{24'h000ABC, 24'h001000, 24'h123400, 24'hFFF800, 24'h018000, 24'h000000};
`endif
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         valid_i = (i < 6);
         if (i < 6) begin mantissa_i = vm[i]; exponent_i = ve[i]; end
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (valid_o !== 1'b1 || num_o !== vx[i-2] || err_o !== 1'b0) begin
               failures++;
               $display("FAIL basic_%0d: got vld=%b num=%h err=%b expected 1/%h/0", i-2, valid_o, num_o, err_o, vx[i-2]);
            end
         end else if (i == 1) begin
            checks++;
            if (valid_o !== 1'b0) begin
               failures++;
               $display("FAIL basic_latency: got vld=%b expected 0 one edge after first input", valid_o);
            end
         end
      end
      @(posedge clk); #1; valid_i = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_illegal();
      logic [7:0] cx[5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         valid_i = (i < 2);
         mantissa_i = (i == 0) ? 12'h123 : 12'h000;
         exponent_i = (i == 0) ? 4'd13 : 4'd15;
         @(negedge clk);
         if (i == 2 || i == 3) begin
            checks++;
            if (valid_o !== 1'b1 || num_o !== 24'hFFFFFF || err_o !== 1'b1) begin
               failures++;
               $display("FAIL illegal_%0d: got vld=%b num=%h err=%b expected 1/ffffff/1", i-2, valid_o, num_o, err_o);
            end
         end
         if (i >= 2) begin
            checks++;
            if (err_cnt_o !== cx[i]) begin
               failures++;
               $display("FAIL illegal_cnt_%0d: got %0d expected %0d", i, err_cnt_o, cx[i]);
            end
         end
      end
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         valid_i = 1'b1; mantissa_i = 12'($urandom); exponent_i = 4'($urandom_range(13, 15));
      end
      @(posedge clk); #1; valid_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (err_cnt_o !== 8'hFF) begin
         failures++;
         $display("FAIL err_cnt_saturate: got %h expected ff", err_cnt_o);
      end
   endtask

   task automatic test_backpressure();
      logic [11:0] bm[8];
      logic [3:0]  be[8];
      int idx = 0, cyc = 0, drops = 0;
      for (int i = 0; i < 8; i++) begin
         bm[i] = 12'($urandom); be[i] = 4'($urandom_range(0, 15));
      end
      while (idx < 8 && cyc < 100) begin
         @(posedge clk); #1;
         valid_i = 1'b1; mantissa_i = bm[idx]; exponent_i = be[idx];
         ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(negedge clk);
         if (ready_o) idx++; else drops++;
         cyc++;
      end
      checks++;
      if (idx != 8 || drops == 0) begin
         failures++;
         $display("FAIL backpressure_stream: got accepted=%0d stalls=%0d expected 8 accepted with stalls", idx, drops);
      end
      @(posedge clk); #1; valid_i = 1'b0; ready_i = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL backpressure_drain: got %0d beats still pending expected 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         valid_i = 1'($urandom); mantissa_i = 12'($urandom);
         exponent_i = 4'($urandom); ready_i = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1; valid_i = 1'b0; ready_i = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL random_drain: got %0d beats still pending expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         valid_i = 1'b1; mantissa_i = 12'h3C3; exponent_i = 4'd14;
      end
      @(posedge clk); #1;
      reset = 1'b1; mantissa_i = 12'h111; exponent_i = 4'd2;
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ready: got %b expected 0", ready_o);
      end
      @(posedge clk); #1;
      reset = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0 || err_cnt_o !== 8'h00 || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_flush: got vld=%b cnt=%h rdy=%b expected 0/00/1", valid_o, err_cnt_o, ready_o);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_capture: got vld=%b expected 0", valid_o);
      end
   endtask

   task automatic test_round_trip();
      logic [23:0] xs[24];
      logic [23:0] trunc[24];
      int p, e;
      for (int i = 0; i < 24; i++) begin
         xs[i] = (i == 0) ? 24'h123456 : 24'($urandom) >> $urandom_range(0, 14);
         trunc[i] = xs[i];
      end
      ready_i = 1'b1;
      for (int i = 0; i < 26; i++) begin
         @(posedge clk); #1;
         valid_i = (i < 24);
         if (i < 24) begin
            if (xs[i] < 24'd4096) begin
               e = 0; mantissa_i = xs[i][11:0];
            end else begin
               p = 0;
               for (int b = 0; b < 24; b++) if (xs[i][b]) p = b;
               e = p - 11;
               mantissa_i = 12'(xs[i] >> (e - 1));
               trunc[i] = xs[i] & ~24'((1 << (e - 1)) - 1);
            end
            exponent_i = 4'(e);
         end
         @(negedge clk);
`ifndef DECOMP_ROUND_EN
         if (i >= 2) begin
            checks++;
            if (valid_o !== 1'b1 || num_o !== trunc[i-2]) begin
               failures++;
               $display("FAIL round_trip_%0d: got vld=%b num=%h expected 1/%h (x=%h)", i-2, valid_o, num_o, trunc[i-2], xs[i-2]);
            end
         end
`endif
      end
      @(posedge clk); #1; valid_i = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_round_trip();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
